dlfloat_mult_pipe: RTL

Parametrised, pipelined DLfloat multiplier: the streaming successor of the single-register DLfloat16 multiplier. It decodes two DLfloat operands, multiplies the significands, then normalises, rounds, saturates and packs the result. It adds a valid/ready handshake with full backpressure, a selectable rounding mode, and exception flags. It sits between operand FIFOs and the accumulator in the MAC datapath.

---
 rtl/dlfloat_pkg.sv | 39 +++
 rtl/dlfloat_round.sv | 77 +++++++
 rtl/dlfloat_mult_pipe.sv | 138 +++++++++++++
 3 files changed

// File: rtl/dlfloat_pkg.sv
// Shared DLfloat definitions: default format widths, special encodings,
// flag bit positions and operand classification helpers.
package dlfloat_pkg;

  localparam int DEF_EXP_W = 6;
  localparam int DEF_MAN_W = 9;
  localparam int DEF_BIAS  = 2**(DEF_EXP_W-1) - 1;

  // Bit positions inside the 3-bit flags word {invalid, overflow, underflow}
  localparam int FLAGS_W  = 3;
  localparam int FLAG_INV = 2;
  localparam int FLAG_OVF = 1;
  localparam int FLAG_UNF = 0;

  // Canonical NaN: every bit of a w-bit word set (sign included)
  function automatic logic [63:0] nan_word(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  // Largest finite magnitude without the sign: exponent all ones, mantissa all ones minus one
  function automatic logic [63:0] max_finite(input int exp_w, input int man_w);
    return (64'd1 << (exp_w + man_w)) - 64'd2;
  endfunction

  // NaN/Inf: exponent and mantissa both all ones, sign ignored
  function automatic logic is_nan(input logic [63:0] x, input int exp_w, input int man_w);
    logic [63:0] mask;
    mask = (64'd1 << (exp_w + man_w)) - 64'd1;
    return (x & mask) == mask;
  endfunction

  // Zero (and flushed subnormals): exponent field clear, mantissa ignored
  function automatic logic is_zero(input logic [63:0] x, input int exp_w, input int man_w);
    logic [63:0] emask;
    emask = (64'd1 << exp_w) - 64'd1;
    return ((x >> man_w) & emask) == 64'd0;
  endfunction

endpackage

// File: rtl/dlfloat_round.sv
// Combinational normalise, round, saturate and pack for a DLfloat significand
// product. Shared between the multiplier and the planned adder.
module dlfloat_round
  import dlfloat_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W,
  parameter int RNE   = 1
) (
  input  logic                      sign,
  input  logic signed [EXP_W+1:0]   exp_in,
  input  logic [2*MAN_W+1:0]        prod,
  output logic [EXP_W+MAN_W:0]      res,
  output logic                      ovf,
  output logic                      unf
);

  localparam int PW = 2*MAN_W + 2;
  localparam int FW = 2*MAN_W + 1;
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] E_ONE = EW'(1);
  localparam logic signed [EW-1:0] E_MAX = EW'((2**EXP_W) - 1);
  localparam logic [EXP_W+MAN_W-1:0] MAXF = (EXP_W+MAN_W)'(max_finite(EXP_W, MAN_W));

  logic [FW-1:0]          frac;
  logic signed [EW-1:0]   exp_n;
  logic signed [EW-1:0]   exp_r;
  logic [MAN_W-1:0]       kept;
  logic [MAN_W-1:0]       man;
  logic                   guard;
  logic                   sticky;
  logic                   inc;
  logic [MAN_W:0]         sum;

  // Normalise: product lies in [1,4); drop the leading one and align fraction bits
  always_comb begin
    if (prod[PW-1]) begin
      frac  = prod[PW-2:0];
      exp_n = exp_in + E_ONE;
    end else begin
      frac  = {prod[PW-3:0], 1'b0};
      exp_n = exp_in;
    end
  end

  // Round: RNE increments on guard when the kept LSB or any lower bit is set
  always_comb begin
    kept   = frac[FW-1 -: MAN_W];
    guard  = frac[MAN_W];
    sticky = |frac[MAN_W-1:0];
    inc    = (RNE != 0) && guard && (kept[0] || sticky);
    sum    = {1'b0, kept} + {{MAN_W{1'b0}}, inc};
    if (sum[MAN_W]) begin
      man   = '0;
      exp_r = exp_n + E_ONE;
    end else begin
      man   = sum[MAN_W-1:0];
      exp_r = exp_n;
    end
  end

  // Saturate and pack; a result that would encode as NaN clamps to max finite
  always_comb begin
    res = '0;
    ovf = 1'b0;
    unf = 1'b0;
    if (exp_r < E_ONE) begin
      unf = 1'b1;
    end else if ((exp_r > E_MAX) || ((exp_r == E_MAX) && (&man))) begin
      ovf = 1'b1;
      res = {sign, MAXF};
    end else begin
      res = {sign, exp_r[EXP_W-1:0], man};
    end
  end

endmodule

// File: rtl/dlfloat_mult_pipe.sv
// Streaming DLfloat multiplier: operand capture, decode, significand multiply,
// then round/pack into a held output register. A single global advance signal
// stalls every stage together when the output is full and not being taken.
module dlfloat_mult_pipe
  import dlfloat_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W,
  parameter int BIAS  = 2**(EXP_W-1) - 1,
  parameter int RNE   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   c,
  output logic [FLAGS_W-1:0]     flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 1;
  localparam int PW = 2*MAN_W + 2;
  localparam int EW = EXP_W + 2;
  localparam logic [W-1:0]         NAN_C  = W'(nan_word(W));
  localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS);

  logic adv;

  logic               vld_p0, vld_p1, vld_p2;
  logic [W-1:0]       a_p0, b_p0;

  logic               sign_s1, nan_s1, zero_s1;
  logic signed [EW-1:0] exp_s1;

  logic               sign_p1, nan_p1, zero_p1;
  logic signed [EW-1:0] exp_p1;
  logic [SW-1:0]      siga_p1, sigb_p1;

  logic               sign_p2, nan_p2, zero_p2;
  logic signed [EW-1:0] exp_p2;
  logic [PW-1:0]      prod_p2;

  logic [W-1:0]       rnd_c;
  logic               rnd_ovf, rnd_unf;
  logic [W-1:0]       c_s3;
  logic [FLAGS_W-1:0] flags_s3;

  // Global advance: everything moves unless a result is waiting and refused
  always_comb begin
    adv      = !out_valid || out_ready;
    in_ready = adv;
  end

  // S1 decode: sign, biased exponent sum and special-operand detection
  always_comb begin
    sign_s1 = a_p0[W-1] ^ b_p0[W-1];
    exp_s1  = $signed({2'b00, a_p0[W-2:MAN_W]}) + $signed({2'b00, b_p0[W-2:MAN_W]}) - BIAS_S;
    nan_s1  = is_nan(64'(a_p0), EXP_W, MAN_W) || is_nan(64'(b_p0), EXP_W, MAN_W);
    zero_s1 = is_zero(64'(a_p0), EXP_W, MAN_W) || is_zero(64'(b_p0), EXP_W, MAN_W);
  end

  // S3 result select: NaN beats zero beats the rounded product
  always_comb begin
    c_s3               = rnd_c;
    flags_s3           = '0;
    flags_s3[FLAG_OVF] = rnd_ovf;
    flags_s3[FLAG_UNF] = rnd_unf;
    if (nan_p2) begin
      c_s3               = NAN_C;
      flags_s3           = '0;
      flags_s3[FLAG_INV] = 1'b1;
    end else if (zero_p2) begin
      c_s3     = '0;
      flags_s3 = '0;
    end
  end

  dlfloat_round #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W),
    .RNE   (RNE)
  ) u_round (
    .sign   (sign_p2),
    .exp_in (exp_p2),
    .prod   (prod_p2),
    .res    (rnd_c),
    .ovf    (rnd_ovf),
    .unf    (rnd_unf)
  );

  // Stage valids and the output register; reset discards everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      out_valid <= 1'b0;
      c         <= '0;
      flags     <= '0;
    end else if (adv) begin
      vld_p0    <= in_valid;
      vld_p1    <= vld_p0;
      vld_p2    <= vld_p1;
      out_valid <= vld_p2;
      if (vld_p2) begin
        c     <= c_s3;
        flags <= flags_s3;
      end
    end
  end

  // Datapath registers: capture (p0), decode (p1), multiply (p2)
  always_ff @(posedge clk) begin
    if (adv) begin
      // ---- p0: operand capture ----
      a_p0    <= a;
      b_p0    <= b;
      // ---- p1: decoded operands ----
      sign_p1 <= sign_s1;
      exp_p1  <= exp_s1;
      nan_p1  <= nan_s1;
      zero_p1 <= zero_s1;
      siga_p1 <= {1'b1, a_p0[MAN_W-1:0]};
      sigb_p1 <= {1'b1, b_p0[MAN_W-1:0]};
      // ---- p2: significand product ----
      sign_p2 <= sign_p1;
      exp_p2  <= exp_p1;
      nan_p2  <= nan_p1;
      zero_p2 <= zero_p1;
      prod_p2 <= {{SW{1'b0}}, siga_p1} * {{SW{1'b0}}, sigb_p1};
    end
  end

endmodule
